// File: rtl/vote_collector.sv
//==============================================================================
// Module      : vote_collector
// Description : Four-voter yes/no ballot collector with per-button debounce
//               and a ballot timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vote_collector #(
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn_yes,
    input  logic [3:0] btn_no,
    output logic [3:0] votes,
    output logic [3:0] present,
    output logic       busy,
    output logic       valid
);

    localparam logic [2:0] c_deb_max   = 3'(DEBOUNCE);
    localparam logic [7:0] c_timer_end = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [2:0] r_cnt_yes [4];
    logic [2:0] r_cnt_no  [4];
    logic [2:0] w_yes_nxt [4];
    logic [2:0] w_no_nxt  [4];
    logic [3:0] w_yes_q;
    logic [3:0] w_no_q;
    logic [3:0] w_reg;

    // Counters only run in COLLECT; qualification looks at the post-edge value.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_yes_nxt[n] = 3'd0;
            w_no_nxt[n]  = 3'd0;
            if (r_state == S_COLLECT) begin
                if (btn_yes[n])
                    w_yes_nxt[n] = (r_cnt_yes[n] == c_deb_max) ? c_deb_max : r_cnt_yes[n] + 3'd1;
                if (btn_no[n])
                    w_no_nxt[n] = (r_cnt_no[n] == c_deb_max) ? c_deb_max : r_cnt_no[n] + 3'd1;
            end
            w_yes_q[n] = (w_yes_nxt[n] == c_deb_max);
            w_no_q[n]  = (w_no_nxt[n] == c_deb_max);
            w_reg[n]   = (r_state == S_COLLECT) && !present[n] && (w_yes_q[n] ^ w_no_q[n]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COLLECT;
            S_COLLECT: if ((present == 4'b1111) || (r_timer == c_timer_end)) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            votes   <= 4'd0;
            present <= 4'd0;
            for (int n = 0; n < 4; n++) begin
                r_cnt_yes[n] <= 3'd0;
                r_cnt_no[n]  <= 3'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            for (int n = 0; n < 4; n++) begin
                r_cnt_yes[n] <= w_yes_nxt[n];
                r_cnt_no[n]  <= w_no_nxt[n];
            end
            if ((r_state == S_IDLE) && start) begin
                r_timer <= 8'd0;
                votes   <= 4'd0;
                present <= 4'd0;
            end else if (r_state == S_COLLECT) begin
                if (w_state_nxt == S_COLLECT)
                    r_timer <= r_timer + 8'd1;
                // A vote qualifying on the closing edge is still captured.
                for (int n = 0; n < 4; n++) begin
                    if (w_reg[n]) begin
                        present[n] <= 1'b1;
                        votes[n]   <= w_yes_q[n];
                    end
                end
            end
        end
    end

    assign busy  = (r_state == S_COLLECT);
    assign valid = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_vote_collector.sv
//==============================================================================
// Module      : tb_vote_collector
// Description : Self-checking bench for vote_collector, directed scenarios
//               plus randomized traffic against a ballot-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vote_collector;

    localparam int D = 3;
    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] btn_yes;
    logic [3:0] btn_no;
    logic [3:0] votes;
    logic [3:0] present;
    logic       busy;
    logic       valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Ballot-level model: phase 0 idle, 1 collecting, 2 closed
    int         m_phase = 0;
    int         m_edges = 0;
    int         m_run_yes [4];
    int         m_run_no  [4];
    logic [3:0] m_votes   = 4'd0;
    logic [3:0] m_present = 4'd0;

    vote_collector #(.DEBOUNCE(D), .TIMEOUT(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .btn_yes (btn_yes),
        .btn_no  (btn_no),
        .votes   (votes),
        .present (present),
        .busy    (busy),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic clear_runs();
        for (int i = 0; i < 4; i++) begin
            m_run_yes[i] = 0;
            m_run_no[i]  = 0;
        end
    endtask

    // A press qualifies once it has been held for at least D consecutive edges.
    task automatic model_edge();
        logic [3:0] old_p;
        logic       qy, qn;
        old_p = m_present;
        if (rst) begin
            m_phase = 0; m_edges = 0; m_votes = 4'd0; m_present = 4'd0;
            clear_runs();
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_edges = 0; m_votes = 4'd0; m_present = 4'd0;
            end
            clear_runs();
        end else if (m_phase == 1) begin
            for (int i = 0; i < 4; i++) begin
                m_run_yes[i] = btn_yes[i] ? m_run_yes[i] + 1 : 0;
                m_run_no[i]  = btn_no[i]  ? m_run_no[i]  + 1 : 0;
                qy = (m_run_yes[i] >= D);
                qn = (m_run_no[i]  >= D);
                if (!m_present[i] && (qy != qn)) begin
                    m_present[i] = 1'b1;
                    m_votes[i]   = qy;
                end
            end
            m_edges++;
            if (old_p == 4'b1111 || m_edges == T) m_phase = 2;
        end else begin
            m_phase = 0;
            clear_runs();
        end
    endtask

    task automatic tick(input logic s, input logic [3:0] y, input logic [3:0] n, input logic r);
        start = s; btn_yes = y; btn_no = n; rst = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        tick(1'b1, 4'hF, 4'd0, 1'b1);
        n_checks++;
        if ({votes, present, busy, valid} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset: got votes=%b present=%b busy=%b valid=%b, expected all 0", votes, present, busy, valid);
        end
    endtask

    task automatic test_full_ballot();
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 3; k++) tick(1'b0, 4'b0101, 4'b1010, 1'b0);
        n_checks++;
        if (present !== 4'b1111 || busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_edge3: got present=%b busy=%b valid=%b, expected 1111 1 0", present, busy, valid);
        end
        tick(1'b0, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || votes !== 4'b0101) begin
            n_fail++;
            $display("FAIL full_edge4: got valid=%b busy=%b votes=%b, expected 1 0 0101", valid, busy, votes);
        end
        tick(1'b0, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (valid !== 1'b0 || votes !== 4'b0101 || present !== 4'b1111) begin
            n_fail++;
            $display("FAIL full_hold: got valid=%b votes=%b present=%b, expected 0 0101 1111", valid, votes, present);
        end
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 4 * T && seen == 0; k++) begin
            tick(1'b0, (k <= 3) ? 4'b1000 : 4'd0, 4'd0, 1'b0);
            if (valid === 1'b1) seen = k;
        end
        n_checks++;
        if (seen != T) begin
            n_fail++;
            $display("FAIL timeout_len: got valid after %0d collect cycles, expected %0d", seen, T);
        end
        n_checks++;
        if (votes !== 4'b1000 || present !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_ballot: got votes=%b present=%b, expected 1000 1000", votes, present);
        end
        tick(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic wait_close(input string tag);
        int ok;
        ok = 0;
        for (int k = 0; k < 4 * T && ok == 0; k++) begin
            tick(1'b0, 4'd0, 4'd0, 1'b0);
            if (valid === 1'b1) ok = 1;
        end
        n_checks++;
        if (ok == 0) begin
            n_fail++;
            $display("FAIL %s_close: got no valid pulse within %0d cycles, expected one", tag, 4 * T);
        end
        tick(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_glitch();
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        tick(1'b0, 4'b0010, 4'd0, 1'b0);
        tick(1'b0, 4'b0010, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (present[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_short: got present[1]=%b, expected 0", present[1]);
        end
        for (int k = 0; k < 3; k++) tick(1'b0, 4'b0010, 4'd0, 1'b0);
        n_checks++;
        if (present[1] !== 1'b1 || votes[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_held: got present[1]=%b votes[1]=%b, expected 1 1", present[1], votes[1]);
        end
        wait_close("glitch");
    endtask

    task automatic test_conflict();
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 4'b0001, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 4'd0, 4'b0001, 1'b0);
        n_checks++;
        if (votes[0] !== 1'b1 || present[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL change_mind: got votes[0]=%b present[0]=%b, expected 1 1", votes[0], present[0]);
        end
        for (int k = 0; k < 5; k++) tick(1'b0, 4'b0100, 4'b0100, 1'b0);
        n_checks++;
        if (present[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_hold: got present[2]=%b, expected 0", present[2]);
        end
        tick(1'b0, 4'b0100, 4'd0, 1'b0);
        n_checks++;
        if (present[2] !== 1'b1 || votes[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_release: got present[2]=%b votes[2]=%b, expected 1 1", present[2], votes[2]);
        end
        wait_close("conflict");
    endtask

    task automatic test_control();
        int seen;
        seen = 0;
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 4 * T && seen == 0; k++) begin
            tick((k >= 4 && k <= 6) || k == T, (k <= 3) ? 4'b0001 : 4'd0, 4'd0, 1'b0);
            if (valid === 1'b1) seen = k;
        end
        n_checks++;
        if (seen != T || votes !== 4'b0001) begin
            n_fail++;
            $display("FAIL start_ignored: got close at %0d votes=%b, expected %0d 0001", seen, votes, T);
        end
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: got busy=%b, expected 0", busy);
        end
        tick(1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 4'b0001, 4'd0, 1'b0);
        tick(1'b0, 4'b0001, 4'd0, 1'b1);
        n_checks++;
        if ({votes, present, busy, valid} !== 10'd0) begin
            n_fail++;
            $display("FAIL abort: got votes=%b present=%b busy=%b valid=%b, expected all 0", votes, present, busy, valid);
        end
        seen = 0;
        for (int k = 0; k < 2 * T; k++) begin
            tick(1'b0, 4'd0, 4'd0, 1'b0);
            if (valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [3:0] ry, rn;
        ry = 4'd0; rn = 4'd0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(3) == 0) begin
                ry = 4'($urandom) & 4'($urandom);
                rn = 4'($urandom) & 4'($urandom);
            end
            tick($urandom_range(7) == 0, ry, rn, $urandom_range(149) == 0);
            n_checks++;
            if (votes !== m_votes || present !== m_present) begin
                n_fail++;
                $display("FAIL rand_ballot@%0d: got votes=%b present=%b, expected %b %b", k, votes, present, m_votes, m_present);
            end
            n_checks++;
            if (busy !== (m_phase == 1) || valid !== (m_phase == 2)) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: got busy=%b valid=%b, expected %b %b", k, busy, valid, m_phase == 1, m_phase == 2);
            end
        end
    endtask

    initial begin
        clear_runs();
        start = 1'b0; btn_yes = 4'd0; btn_no = 4'd0; rst = 1'b1;
        test_reset();
        test_full_ballot();
        test_timeout();
        test_glitch();
        test_conflict();
        test_control();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
